seq_divider: RTL and testbench
==============================

# seq_divider

Parametrised multi-cycle integer divider for the MIPS datapath, serving both DIV (signed) and DIVU (unsigned) from one instance. It computes a WIDTH-bit quotient (LO) and remainder (HI) with a start/busy/done handshake, one quotient bit per cycle. It flags divide-by-zero without entering the iteration loop. A synchronous reset aborts an operation in flight.

## Interface
- WIDTH, 32, operand, quotient and remainder width; legal range 4..64.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- busy  output  1  high while an operation occupies the unit (BUSY and FINISH states).
- done  output  1  one-cycle pulse when results are valid.
- div_by_zero  output  1  set when an accepted request had divisor == 0.
- quotient  output  WIDTH  LO result, registered.
- remainder  output  WIDTH  HI result, registered.

## Operation
- FSM states: IDLE, BUSY, FINISH.
- IDLE, start=1, divisor!=0:
  - Latch the operand magnitudes: abs() when is_signed is 1, raw value when it is 0. |MIN_INT| = 2^(WIDTH-1) fits unsigned WIDTH bits.
  - Latch neg_q = is_signed & (dividend MSB ^ divisor MSB).
  - Latch neg_r = is_signed & dividend MSB.
  - Clear the partial remainder (WIDTH+1 bits) and the count. Clear div_by_zero. Go to BUSY.
- IDLE, start=1, divisor==0:
  - Set div_by_zero=1 and pulse done on the next cycle. Stay IDLE.
  - quotient and remainder keep their previous values.
- BUSY: unsigned restoring step per cycle.
  - Shift {rem, dividend_mag} left by 1.
  - If rem >= divisor_mag: subtract it, and the shifted-in quotient bit is 1.
  - After WIDTH steps go to FINISH.
- FINISH:
  - quotient <= neg_q ? -q : q.
  - remainder <= neg_r ? -r : r.
  - done=1 for this one cycle; return to IDLE.
- Semantics: truncation toward zero; the remainder takes the sign of the dividend. The identity dividend = q*divisor + r holds modulo 2^WIDTH.
- Overflow: signed MIN_INT / -1 gives quotient = MIN_INT and remainder = 0, with no flag.
- start while busy is ignored; there is no queueing, and operand changes are don't-care.
- div_by_zero is sticky until the next accepted start or rst.

## Timing
- Reset values: busy=0, done=0, div_by_zero=0, quotient=0, remainder=0; state IDLE.
- Edge E0 (start accepted, divisor!=0): busy=1 from E0.
- Edges E1..E_WIDTH: iteration steps.
- Edge E_{WIDTH+1}: results registered, done=1, busy=0.
- Latency: done visible WIDTH+1 cycles after the accepting edge (33 for WIDTH=32). Throughput is one op per WIDTH+1 cycles.
- A start held high in the cycle where done=1 is accepted at the next edge: back-to-back ops with no bubble.
- Divide-by-zero: done=1 and div_by_zero=1 visible after E0; busy never asserts.
- quotient and remainder change only at the FINISH edge (or on rst). They are stable between done pulses.
- rst during BUSY or FINISH:
  - Takes priority over every other event.
  - Next cycle: IDLE with all outputs at reset values. No done pulse for the aborted op.
- rst and start in the same cycle: rst wins and the start is dropped.

## Test plan
- WIDTH=32, signed:
  - 100 / 7 -> quotient=14, remainder=2, done exactly 33 cycles after accept, busy high for those 33 cycles.
  - -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - 7 / -2 -> quotient=0xFFFFFFFD, remainder=1.
- WIDTH=32, mode select on the same operands:
  - Unsigned 0xFFFFFFFF / 2 -> quotient=0x7FFFFFFF, remainder=1.
  - Signed 0xFFFFFFFF / 2 -> quotient=0, remainder=0xFFFFFFFF.
- Edge operands:
  - Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
  - x / 0 -> div_by_zero=1 and done 1 cycle after start, prior quotient/remainder unchanged.
  - The next valid start clears div_by_zero.
- Reset and back-to-back:
  - rst asserted 10 cycles into 100/7 -> no done pulse, outputs at 0 next cycle.
  - A following 9/3 -> quotient=3, remainder=0.
  - start held high through done accepts the second op the same cycle done=1.
- WIDTH=8 instance:
  - Unsigned 200/3 -> quotient=66, remainder=2, done 9 cycles after accept.
  - Signed -128/3 -> quotient=0xD6, remainder=0xFE.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// start/busy/done handshake, divide-by-zero detected without iterating.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FINISH
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quo_out_q;
  logic [WIDTH-1:0] rem_out_q;

  logic [WIDTH:0]   shifted_c;
  logic             fits_c;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] dvd_mag_c;
  logic [WIDTH-1:0] dsr_mag_c;
  logic [WIDTH-1:0] quo_fin_c;
  logic [WIDTH-1:0] rem_fin_c;

  // One restoring step on the (WIDTH+1)-bit working remainder, plus operand
  // magnitudes at accept time and sign correction at finish time.
  always_comb begin
    shifted_c = {rem_q, dvd_q[WIDTH-1]};
    fits_c    = shifted_c >= {1'b0, dsr_q};
    rem_d     = fits_c ? WIDTH'(shifted_c - {1'b0, dsr_q}) : WIDTH'(shifted_c);
    dvd_d     = {dvd_q[WIDTH-2:0], fits_c};
    dvd_mag_c = (is_signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    dsr_mag_c = (is_signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
    quo_fin_c = neg_quo_q ? -dvd_q : dvd_q;
    rem_fin_c = neg_rem_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (divisor_i == '0) begin
              dbz_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              dvd_q     <= dvd_mag_c;
              dsr_q     <= dsr_mag_c;
              neg_quo_q <= is_signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
              neg_rem_q <= is_signed_i & dividend_i[WIDTH-1];
              rem_q     <= '0;
              cnt_q     <= '0;
              dbz_q     <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          quo_out_q <= quo_fin_c;
          rem_out_q <= rem_fin_c;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;
  assign quotient_o    = quo_out_q;
  assign remainder_o   = rem_out_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: WIDTH=32 and WIDTH=8 instances, vector table plus
// hand sequences for reset abort and back-to-back issue, checked via a scoreboard.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start32 = 1'b0, sgn32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, dbz32;
  logic [31:0] q32, r32;

  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dbz8;
  logic [7:0]  q8, r8;

  seq_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start_i(start32), .is_signed_i(sgn32),
    .dividend_i(a32), .divisor_i(b32), .busy_o(busy32), .done_o(done32),
    .div_by_zero_o(dbz32), .quotient_o(q32), .remainder_o(r32)
  );

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .is_signed_i(sgn8),
    .dividend_i(a8), .divisor_i(b8), .busy_o(busy8), .done_o(done8),
    .div_by_zero_o(dbz8), .quotient_o(q8), .remainder_o(r8)
  );

  typedef struct {
    logic        w8;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic        w8;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          acc;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt32 = 0;
  int   busy_cnt8 = 0;

  function automatic vec_t mk(logic w8, logic sgn, logic [31:0] a, logic [31:0] b,
                              logic [31:0] q, logic [31:0] r, logic dbz);
    vec_t v;
    v.w8 = w8; v.sgn = sgn; v.a = a; v.b = b; v.q = q; v.r = r; v.dbz = dbz;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_done(input logic w8, input logic [31:0] q, input logic [31:0] r,
                            input logic dbz, input int bcnt);
    exp_t  e;
    int    lat;
    string tag;
    tag = w8 ? "w8" : "w32";
    if (scb.size() == 0 || scb[0].w8 != w8) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected_done: got done=1 expected no done (cycle %0d)", tag, cyc);
      return;
    end
    e = scb.pop_front();
    lat = e.dbz ? 0 : (w8 ? 9 : 33);
    cmp({tag, " quotient"},    64'(q),   64'(e.q));
    cmp({tag, " remainder"},   64'(r),   64'(e.r));
    cmp({tag, " div_by_zero"}, 64'(dbz), 64'(e.dbz));
    cmp({tag, " latency"},     64'(cyc - e.acc), 64'(lat));
    cmp({tag, " busy_cycles"}, 64'(bcnt), 64'(lat));
  endtask

  // Scoreboard consumer: one pop per done pulse, busy cycles tallied per op.
  initial begin
    forever begin
      @(negedge clk);
      if (done32) begin
        check_done(1'b0, q32, r32, dbz32, busy_cnt32);
        busy_cnt32 = 0;
      end else if (busy32) begin
        busy_cnt32++;
      end
      if (done8) begin
        check_done(1'b1, {24'b0, q8}, {24'b0, r8}, dbz8, busy_cnt8);
        busy_cnt8 = 0;
      end else if (busy8) begin
        busy_cnt8++;
      end
    end
  end

  task automatic drive(input logic w8, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, output int acc);
    if (w8) begin
      start8 = 1'b1; sgn8 = sgn; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = 1'b1; sgn32 = sgn; a32 = a; b32 = b;
    end
    @(posedge clk);
    #1;
    start32 = 1'b0;
    start8  = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && scb.size() != 0; i++) @(negedge clk);
    if (scb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending results expected 0", scb.size());
      scb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v);
    int   acc;
    exp_t e;
    drive(v.w8, v.sgn, v.a, v.b, acc);
    e.w8 = v.w8; e.q = v.q; e.r = v.r; e.dbz = v.dbz; e.acc = acc;
    scb.push_back(e);
    wait_drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, " busy32"}, 64'(busy32), 64'(0));
    cmp({tag, " done32"}, 64'(done32), 64'(0));
    cmp({tag, " dbz32"},  64'(dbz32),  64'(0));
    cmp({tag, " q32"},    64'(q32),    64'(0));
    cmp({tag, " r32"},    64'(r32),    64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   acc;
    exp_t e;
    logic signed [31:0] sa, sd;
    bit   seen;

    // w8, signed, dividend, divisor, quotient, remainder, div_by_zero
    tbl.push_back(mk(0, 1, 32'd100,        32'd7,          32'd14,         32'd2,          0));
    tbl.push_back(mk(0, 1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   0));
    tbl.push_back(mk(0, 1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          0));
    tbl.push_back(mk(0, 0, 32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF,   32'd1,          0));
    tbl.push_back(mk(0, 1, 32'hFFFFFFFF,   32'd2,          32'd0,          32'hFFFFFFFF,   0));
    tbl.push_back(mk(0, 1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          0));
    tbl.push_back(mk(0, 1, 32'd12345,      32'd0,          32'h80000000,   32'd0,          1));
    tbl.push_back(mk(0, 0, 32'd0,          32'd5,          32'd0,          32'd0,          0));
    tbl.push_back(mk(0, 0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          0));
    tbl.push_back(mk(0, 0, 32'd5,          32'd9,          32'd0,          32'd5,          0));
    tbl.push_back(mk(0, 1, 32'h80000000,   32'h7FFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   0));
    tbl.push_back(mk(1, 0, 32'd200,        32'd3,          32'd66,         32'd2,          0));
    tbl.push_back(mk(1, 1, 32'h80,         32'd3,          32'hD6,         32'hFE,         0));
    tbl.push_back(mk(1, 1, 32'h7F,         32'hFF,         32'h81,         32'h00,         0));
    tbl.push_back(mk(1, 0, 32'hFF,         32'hFF,         32'h01,         32'h00,         0));
    tbl.push_back(mk(1, 0, 32'h10,         32'h00,         32'h01,         32'h00,         1));
    tbl.push_back(mk(1, 1, 32'h80,         32'hFF,         32'h80,         32'h00,         0));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    cmp("reset busy8", 64'(busy8), 64'(0));
    cmp("reset q8",    64'(q8),    64'(0));
    @(posedge clk);
    #1;

    foreach (tbl[i]) run(tbl[i]);

    // Divide-by-zero, then an accepted start clears the flag at once.
    run(mk(0, 1, 32'd9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1));
    drive(0, 1, 32'd100, 32'd7, acc);
    @(negedge clk);
    cmp("dbz_cleared_on_accept", 64'(dbz32), 64'(0));
    cmp("busy_after_accept",     64'(busy32), 64'(1));

    // Abort that op ten cycles in; no done may follow.
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    busy_cnt32 = 0;
    @(negedge clk);
    check_reset_outputs("abort");
    repeat (40) @(posedge clk);
    #1;
    run(mk(0, 1, 32'd9, 32'd3, 32'd3, 32'd0, 0));

    // Back-to-back: start held through done, second op accepted with no bubble.
    start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd1000; b32 = 32'd10;
    @(posedge clk);
    #1;
    e.w8 = 0; e.q = 32'd100; e.r = 32'd0; e.dbz = 0; e.acc = cyc;
    scb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = done32;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL b2b_first_done: got no done expected done within 60 cycles");
    end
    sgn32 = 1'b1; a32 = 32'hFFFFFFB3; b32 = 32'd7;
    e.w8 = 0; e.q = 32'hFFFFFFF5; e.r = 32'd0; e.dbz = 0; e.acc = cyc + 1;
    scb.push_back(e);
    @(posedge clk);
    #1 start32 = 1'b0;
    cmp("b2b_second_accepted", 64'(busy32), 64'(1));
    wait_drain();

    // Randomised operands against a behavioural reference.
    for (int i = 0; i < 8; i++) begin
      v.w8  = 1'b0;
      v.sgn = 1'($urandom_range(0, 1));
      v.a   = $urandom;
      v.b   = $urandom >> $urandom_range(0, 28);
      v.dbz = 1'b0;
      if (v.b == 32'd0) v.b = 32'd1;
      if (v.a == 32'h80000000 && v.b == 32'hFFFFFFFF) v.b = 32'd3;
      if (v.sgn) begin
        sa = v.a;
        sd = v.b;
        v.q = sa / sd;
        v.r = sa % sd;
      end else begin
        v.q = v.a / v.b;
        v.r = v.a % v.b;
      end
      run(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
